// File: rtl/alien_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alien_pkg
// Description : Shared types and geometry for the alien formation and its
//               renderer: FSM state encoding, index bit-count helper and
//               default pixel geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package alien_pkg;

    typedef enum logic [1:0] {
        MOVE    = 2'd0,
        LANDED  = 2'd1,
        CLEARED = 2'd2
    } state_t;

    localparam int ALIENS_WIDTH  = 20;
    localparam int ALIENS_HEIGHT = 10;
    localparam int SCREEN_W      = 640;

    // Bits needed to hold the value n itself (so an index equal to the
    // count is representable and can be rejected as out of range).
    function automatic int Size(input int n);
        int s;
        s = 1;
        while ((1 << s) <= n) s++;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alien_span.sv
`default_nettype none
// ============================================================================
// Module      : alien_span
// Description : Combinational extent of the live aliens: lowest and highest
//               occupied column, highest occupied row, and any-alive flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alien_span import alien_pkg::*; #(
    parameter int NB_LIN = 2,
    parameter int NB_COL = 2,
    parameter int SIZE_I = Size(NB_LIN),
    parameter int SIZE_J = Size(NB_COL)
) (
    input  logic [NB_LIN*NB_COL-1:0] alive,
    output logic [SIZE_J-1:0]        jMin,
    output logic [SIZE_J-1:0]        jMax,
    output logic [SIZE_I-1:0]        iMax,
    output logic                     any
);

    logic [NB_COL-1:0] w_colLive;
    logic [NB_LIN-1:0] w_rowLive;

    // Collapse the alive mask into per-column and per-row occupancy
    always_comb begin
        w_colLive = '0;
        w_rowLive = '0;
        for (int i = 0; i < NB_LIN; i++) begin
            for (int j = 0; j < NB_COL; j++) begin
                if (alive[NB_COL*i+j]) begin
                    w_colLive[j] = 1'b1;
                    w_rowLive[i] = 1'b1;
                end
            end
        end
    end

    // Pick the outermost occupied column on each side and the lowest row
    always_comb begin
        jMin = '0;
        jMax = '0;
        iMax = '0;
        for (int j = NB_COL - 1; j >= 0; j--) begin
            if (w_colLive[j]) jMin = SIZE_J'(j);
        end
        for (int j = 0; j < NB_COL; j++) begin
            if (w_colLive[j]) jMax = SIZE_J'(j);
        end
        for (int i = 0; i < NB_LIN; i++) begin
            if (w_rowLive[i]) iMax = SIZE_I'(i);
        end
    end

    assign any = |alive;

endmodule
`default_nettype wire

// File: rtl/alien_formation.sv
`default_nettype none
// ============================================================================
// Module      : alien_formation
// Description : Movement and lifetime controller for the alien grid. Sweeps
//               the formation sideways once per step interval, descends and
//               reverses at the screen edges, clears aliens on hits and flags
//               landing / clearance.
// Revision    : 1.0 - initial release
// ============================================================================
module alien_formation import alien_pkg::*; #(
    parameter int NB_LIN          = 2,
    parameter int NB_COL          = 2,
    parameter int ALIENS_WIDTH    = alien_pkg::ALIENS_WIDTH,
    parameter int ALIENS_HEIGHT   = alien_pkg::ALIENS_HEIGHT,
    parameter int X_START         = 20,
    parameter int Y_START         = 20,
    parameter int STEP_X          = 4,
    parameter int STEP_Y          = 10,
    parameter int FRAMES_PER_STEP = 2,
    parameter int SCREEN_W        = alien_pkg::SCREEN_W,
    parameter int Y_LIMIT         = 400
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frameTick,
    input  logic                        hit,
    input  logic [Size(NB_LIN)-1:0]     hitLin,
    input  logic [Size(NB_COL)-1:0]     hitCol,
    output logic signed [10:0]          xAlien,
    output logic [9:0]                  yAlien,
    output logic [NB_LIN*NB_COL-1:0]    alive,
    output logic                        dirRight,
    output logic                        landed,
    output logic                        cleared
);

    localparam int SIZE_I = Size(NB_LIN);
    localparam int SIZE_J = Size(NB_COL);
    localparam int CNT_W  = Size(FRAMES_PER_STEP - 1);

    localparam logic [CNT_W-1:0]   c_cntTop = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic signed [11:0] c_halfW  = 12'(ALIENS_WIDTH / 2);
    localparam logic signed [11:0] c_halfH  = 12'(ALIENS_HEIGHT / 2);
    localparam logic signed [11:0] c_maxX   = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] c_yLimit = 12'(Y_LIMIT);

    state_t                     r_state;
    logic signed [10:0]         r_xAlien;
    logic [9:0]                 r_yAlien;
    logic [NB_LIN*NB_COL-1:0]   r_alive;
    logic                       r_dirRight;
    logic                       r_landed;
    logic                       r_cleared;
    logic [CNT_W-1:0]           r_frameCnt;

    logic [NB_LIN*NB_COL-1:0]   w_aliveNext;
    logic [SIZE_J-1:0]          w_jMin;
    logic [SIZE_J-1:0]          w_jMax;
    logic [SIZE_I-1:0]          w_iMax;
    logic                       w_any;
    logic                       w_stepFire;
    logic signed [11:0]         w_candX;
    logic signed [11:0]         w_leftEdge;
    logic signed [11:0]         w_rightEdge;
    logic [9:0]                 w_yDown;
    logic signed [11:0]         w_bottomEdge;
    logic                       w_blocked;

    // Apply a pending hit to the mask; out-of-range indices never match
    always_comb begin
        w_aliveNext = r_alive;
        if (hit && r_state == MOVE) begin
            for (int i = 0; i < NB_LIN; i++) begin
                for (int j = 0; j < NB_COL; j++) begin
                    if (int'(hitLin) == i && int'(hitCol) == j) w_aliveNext[NB_COL*i+j] = 1'b0;
                end
            end
        end
    end

    // Edges are taken over the post-hit mask so a same-cycle kill widens the path
    alien_span #(
        .NB_LIN (NB_LIN),
        .NB_COL (NB_COL),
        .SIZE_I (SIZE_I),
        .SIZE_J (SIZE_J)
    ) u_span (
        .alive  (w_aliveNext),
        .jMin   (w_jMin),
        .jMax   (w_jMax),
        .iMax   (w_iMax),
        .any    (w_any)
    );

    // Candidate position and the live-span edges it would produce
    always_comb begin
        w_stepFire   = (r_state == MOVE) && frameTick && (r_frameCnt == c_cntTop);
        w_candX      = r_dirRight ? ({r_xAlien[10], r_xAlien} + 12'(STEP_X))
                                  : ({r_xAlien[10], r_xAlien} - 12'(STEP_X));
        w_leftEdge   = w_candX - c_halfW + 12'(2 * ALIENS_WIDTH * int'(w_jMin));
        w_rightEdge  = w_candX - c_halfW + 12'(ALIENS_WIDTH * (2 * int'(w_jMax) + 1));
        w_yDown      = r_yAlien + 10'(STEP_Y);
        w_bottomEdge = $signed({2'b00, w_yDown}) - c_halfH
                       + 12'(ALIENS_HEIGHT * (2 * int'(w_iMax) + 1));
        w_blocked    = w_any && (r_dirRight ? (w_rightEdge > c_maxX)
                                            : (w_leftEdge < 12'sd0));
    end

    // Formation state machine: move/descend, kill, and terminal freeze
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= MOVE;
            r_xAlien   <= 11'(X_START);
            r_yAlien   <= 10'(Y_START);
            r_alive    <= '1;
            r_dirRight <= 1'b1;
            r_landed   <= 1'b0;
            r_cleared  <= 1'b0;
            r_frameCnt <= '0;
        end else begin
            case (r_state)
                MOVE: begin
                    r_alive <= w_aliveNext;
                    if (frameTick) begin
                        r_frameCnt <= (r_frameCnt == c_cntTop) ? '0 : r_frameCnt + 1'b1;
                    end
                    if (w_stepFire) begin
                        if (w_blocked) begin
                            r_yAlien   <= w_yDown;
                            r_dirRight <= ~r_dirRight;
                        end else begin
                            r_xAlien   <= w_candX[10:0];
                        end
                    end
                    if (!w_any) begin
                        r_state   <= CLEARED;
                        r_cleared <= 1'b1;
                    end else if (w_stepFire && w_blocked && w_bottomEdge >= c_yLimit) begin
                        r_state   <= LANDED;
                        r_landed  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign xAlien   = r_xAlien;
    assign yAlien   = r_yAlien;
    assign alive    = r_alive;
    assign dirRight = r_dirRight;
    assign landed   = r_landed;
    assign cleared  = r_cleared;

endmodule
`default_nettype wire

// File: tb/tb_alien_formation.sv
`default_nettype none
// ============================================================================
// Module      : tb_alien_formation
// Description : Directed self-checking bench for alien_formation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alien_formation;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               frameTick;
    logic               hit;
    logic [1:0]         hitLin;
    logic [1:0]         hitCol;
    logic signed [10:0] xAlien;
    logic [9:0]         yAlien;
    logic [3:0]         alive;
    logic               dirRight;
    logic               landed;
    logic               cleared;

    int nChecks = 0;
    int nFail   = 0;

    alien_formation dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frameTick (frameTick),
        .hit       (hit),
        .hitLin    (hitLin),
        .hitCol    (hitCol),
        .xAlien    (xAlien),
        .yAlien    (yAlien),
        .alive     (alive),
        .dirRight  (dirRight),
        .landed    (landed),
        .cleared   (cleared)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs, sampled 1 time unit after the edge
    task automatic cyc(input logic t, input logic h, input int l, input int c);
        frameTick = t;
        hit       = h;
        hitLin    = 2'(l);
        hitCol    = 2'(c);
        @(posedge clk);
        #1;
        frameTick = 1'b0;
        hit       = 1'b0;
    endtask

    task automatic doStep;
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 0, 0);
    endtask

    task automatic doReset;
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        doReset;
        nChecks++; if (xAlien !== 11'sd20) begin nFail++; $display("FAIL reset_x: got %0d want 20", xAlien); end
        nChecks++; if (yAlien !== 10'd20) begin nFail++; $display("FAIL reset_y: got %0d want 20", yAlien); end
        nChecks++; if (alive !== 4'b1111) begin nFail++; $display("FAIL reset_alive: got %b want 1111", alive); end
        nChecks++; if (dirRight !== 1'b1) begin nFail++; $display("FAIL reset_dir: got %b want 1", dirRight); end
        nChecks++; if (landed !== 1'b0 || cleared !== 1'b0) begin nFail++; $display("FAIL reset_flags: got landed=%b cleared=%b want 0 0", landed, cleared); end
    endtask

    task automatic test_step;
        cyc(1'b1, 1'b0, 0, 0);
        nChecks++; if (xAlien !== 11'sd20) begin nFail++; $display("FAIL step_one_tick_x: got %0d want 20", xAlien); end
        cyc(1'b1, 1'b0, 0, 0);
        nChecks++; if (xAlien !== 11'sd24) begin nFail++; $display("FAIL step_x: got %0d want 24", xAlien); end
        nChecks++; if (yAlien !== 10'd20 || alive !== 4'b1111) begin nFail++; $display("FAIL step_y_alive: got y=%0d alive=%b want 20 1111", yAlien, alive); end
    endtask

    task automatic test_right_edge;
        repeat (141) doStep;
        nChecks++; if (xAlien !== 11'sd588 || dirRight !== 1'b1) begin nFail++; $display("FAIL edge_preload: got x=%0d dir=%b want 588 1", xAlien, dirRight); end
        doStep;
        nChecks++; if (xAlien !== 11'sd588 || yAlien !== 10'd30 || dirRight !== 1'b0) begin nFail++; $display("FAIL edge_descent: got x=%0d y=%0d dir=%b want 588 30 0", xAlien, yAlien, dirRight); end
        doStep;
        nChecks++; if (xAlien !== 11'sd584 || yAlien !== 10'd30) begin nFail++; $display("FAIL edge_reverse: got x=%0d y=%0d want 584 30", xAlien, yAlien); end
    endtask

    task automatic test_span_shrink;
        doReset;
        repeat (142) doStep;
        cyc(1'b0, 1'b1, 0, 1);
        cyc(1'b0, 1'b1, 1, 1);
        nChecks++; if (alive !== 4'b0101) begin nFail++; $display("FAIL shrink_alive: got %b want 0101", alive); end
        doStep;
        nChecks++; if (xAlien !== 11'sd592 || yAlien !== 10'd20 || dirRight !== 1'b1) begin nFail++; $display("FAIL shrink_step: got x=%0d y=%0d dir=%b want 592 20 1", xAlien, yAlien, dirRight); end
    endtask

    task automatic test_landing;
        int  mx, my, cand, steps;
        bit  md, mLanded, early;
        doReset;
        mx = 20; my = 20; md = 1'b1; mLanded = 1'b0; early = 1'b0; steps = 0;
        while (!mLanded && steps < 20000) begin
            doStep;
            steps++;
            cand = md ? mx + 4 : mx - 4;
            if ((md && cand + 50 > 639) || (!md && cand - 10 < 0)) begin
                my += 10;
                md = !md;
                if (my + 25 >= 400) mLanded = 1'b1;
            end else begin
                mx = cand;
            end
            if (!mLanded && landed !== 1'b0) early = 1'b1;
        end
        nChecks++; if (!mLanded || early) begin nFail++; $display("FAIL land_timing: got early=%0d steps=%0d want early=0 within bound", early, steps); end
        nChecks++; if (yAlien !== 10'd380 || my != 380) begin nFail++; $display("FAIL land_y: got %0d want 380", yAlien); end
        nChecks++; if (xAlien !== 11'(mx) || dirRight !== md) begin nFail++; $display("FAIL land_xdir: got x=%0d dir=%b want %0d %b", xAlien, dirRight, mx, md); end
        nChecks++; if (landed !== 1'b1 || cleared !== 1'b0) begin nFail++; $display("FAIL land_flags: got landed=%b cleared=%b want 1 0", landed, cleared); end
        cyc(1'b0, 1'b1, 0, 0);
        doStep;
        doStep;
        nChecks++; if (xAlien !== 11'(mx) || yAlien !== 10'd380 || alive !== 4'b1111 || dirRight !== md) begin nFail++; $display("FAIL land_freeze: got x=%0d y=%0d alive=%b dir=%b want %0d 380 1111 %b", xAlien, yAlien, alive, dirRight, mx, md); end
        nChecks++; if (landed !== 1'b1) begin nFail++; $display("FAIL land_sticky: got %b want 1", landed); end
    endtask

    task automatic test_clear;
        doReset;
        cyc(1'b0, 1'b1, 2, 0);
        nChecks++; if (alive !== 4'b1111) begin nFail++; $display("FAIL clear_oor_lin: got %b want 1111", alive); end
        cyc(1'b0, 1'b1, 0, 2);
        nChecks++; if (alive !== 4'b1111) begin nFail++; $display("FAIL clear_oor_col: got %b want 1111", alive); end
        cyc(1'b0, 1'b1, 0, 0);
        nChecks++; if (alive !== 4'b1110) begin nFail++; $display("FAIL clear_kill00: got %b want 1110", alive); end
        cyc(1'b0, 1'b1, 0, 1);
        nChecks++; if (alive !== 4'b1100) begin nFail++; $display("FAIL clear_kill01: got %b want 1100", alive); end
        cyc(1'b0, 1'b1, 1, 0);
        cyc(1'b0, 1'b1, 1, 0);
        nChecks++; if (alive !== 4'b1000 || cleared !== 1'b0) begin nFail++; $display("FAIL clear_kill10_twice: got alive=%b cleared=%b want 1000 0", alive, cleared); end
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 1, 1);
        nChecks++; if (cleared !== 1'b1 || alive !== 4'b0000 || landed !== 1'b0) begin nFail++; $display("FAIL clear_last: got cleared=%b alive=%b landed=%b want 1 0000 0", cleared, alive, landed); end
        nChecks++; if (yAlien !== 10'd20) begin nFail++; $display("FAIL clear_y: got %0d want 20", yAlien); end
        cyc(1'b0, 1'b1, 0, 0);
        doStep;
        nChecks++; if (cleared !== 1'b1 || alive !== 4'b0000 || landed !== 1'b0 || yAlien !== 10'd20) begin nFail++; $display("FAIL clear_freeze: got cleared=%b alive=%b landed=%b y=%0d want 1 0000 0 20", cleared, alive, landed, yAlien); end
    endtask

    task automatic test_reset_mid;
        doReset;
        doStep;
        cyc(1'b1, 1'b0, 0, 0);
        nChecks++; if (xAlien !== 11'sd24) begin nFail++; $display("FAIL mid_pre_x: got %0d want 24", xAlien); end
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, 0, 0);
        rst_n = 1'b1;
        nChecks++; if (xAlien !== 11'sd20 || yAlien !== 10'd20 || alive !== 4'b1111 || dirRight !== 1'b1) begin nFail++; $display("FAIL mid_reset_vals: got x=%0d y=%0d alive=%b dir=%b want 20 20 1111 1", xAlien, yAlien, alive, dirRight); end
        nChecks++; if (landed !== 1'b0 || cleared !== 1'b0) begin nFail++; $display("FAIL mid_reset_flags: got landed=%b cleared=%b want 0 0", landed, cleared); end
        cyc(1'b1, 1'b0, 0, 0);
        nChecks++; if (xAlien !== 11'sd20) begin nFail++; $display("FAIL mid_counter_restart: got %0d want 20", xAlien); end
        cyc(1'b1, 1'b0, 0, 0);
        nChecks++; if (xAlien !== 11'sd24) begin nFail++; $display("FAIL mid_first_step: got %0d want 24", xAlien); end
    endtask

    initial begin
        rst_n     = 1'b0;
        frameTick = 1'b0;
        hit       = 1'b0;
        hitLin    = 2'd0;
        hitCol    = 2'd0;
        test_reset;
        test_step;
        test_right_edge;
        test_span_shrink;
        test_landing;
        test_clear;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
